// File: rtl/input_conditioner.sv
// Two-channel switch conditioner: 2-flop sync, 4-state debounce FSM, registered rise pulse.
// Define TOGGLE_MODE_EN to turn X/Y into press-toggled latches.
module input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 8
) (
    input  logic CLK,
    input  logic RST,
    input  logic SW_X,
    input  logic SW_Y,
    output logic X,
    output logic Y,
    output logic X_RISE,
    output logic Y_RISE
);

    typedef enum logic [1:0] {
        StStableLo,
        StChkHi,
        StStableHi,
        StChkLo
    } state_e;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0] sw;
    logic [1:0] out_w;
    logic [1:0] rise_w;

    assign sw     = {SW_Y, SW_X};
    assign X      = out_w[0];
    assign Y      = out_w[1];
    assign X_RISE = rise_w[0];
    assign Y_RISE = rise_w[1];

    for (genvar c = 0; c < 2; c++) begin : g_ch
        logic             s1_q, s2_q;
        state_e           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             out_q, out_d;
        logic             rise_q, rise_d;

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                s1_q    <= 1'b0;
                s2_q    <= 1'b0;
                state_q <= StStableLo;
                cnt_q   <= '0;
                out_q   <= 1'b0;
                rise_q  <= 1'b0;
            end else begin
                s1_q    <= sw[c];
                s2_q    <= s1_q;
                state_q <= state_d;
                cnt_q   <= cnt_d;
                out_q   <= out_d;
                rise_q  <= rise_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            out_d   = out_q;
            rise_d  = 1'b0;
            unique case (state_q)
                StStableLo: begin
                    if (s2_q) begin
                        state_d = StChkHi;
                        cnt_d   = '0;
                    end
                end
                StChkHi: begin
                    if (!s2_q) begin
                        state_d = StStableLo;
                    end else if (cnt_q == CntLast) begin
                        state_d = StStableHi;
                        rise_d  = 1'b1;
`ifdef TOGGLE_MODE_EN
                        out_d   = ~out_q;
`else
                        out_d   = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                StStableHi: begin
                    if (!s2_q) begin
                        state_d = StChkLo;
                        cnt_d   = '0;
                    end
                end
                StChkLo: begin
                    if (s2_q) begin
                        state_d = StStableHi;
                    end else if (cnt_q == CntLast) begin
                        state_d = StStableLo;
                        // In toggle mode a release is accepted but leaves the output alone.
`ifdef TOGGLE_MODE_EN
                        out_d   = out_q;
`else
                        out_d   = 1'b0;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = StStableLo;
            endcase
        end

        assign out_w[c]  = out_q;
        assign rise_w[c] = rise_q;
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner: per-cycle scoreboard against a run-length model,
// a segment table of input patterns, and hand sequences for reset and toggle mode.
module tb_input_conditioner;

    localparam int unsigned D = 4;

    logic CLK = 1'b0;
    logic RST;
    logic SW_X, SW_Y;
    logic X, Y, X_RISE, Y_RISE;

    always #5 CLK = ~CLK;

    input_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (8)
    ) dut (
        .CLK   (CLK),
        .RST   (RST),
        .SW_X  (SW_X),
        .SW_Y  (SW_Y),
        .X     (X),
        .Y     (Y),
        .X_RISE(X_RISE),
        .Y_RISE(Y_RISE)
    );

    typedef struct {
        logic x;
        logic y;
        logic xr;
        logic yr;
    } exp_t;

    typedef struct {
        logic  sx;
        logic  sy;
        int    n;
        logic  ex;
        logic  ey;
        int    exr;
        int    eyr;
        string name;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[$];

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    int seg_xr, seg_yr;

    // Model: the output flips once the synchronized level has disagreed with it for D+1
    // consecutive edges; any agreeing edge restarts the run.
    logic m_s1[2], m_s2[2], m_lvl[2], m_tog[2], m_rise[2];
    int   m_run[2];

    task automatic check_bits(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: {X,Y,XR,YR} got %b expected %b", name, act, exp);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_s1[c]   = 1'b0;
            m_s2[c]   = 1'b0;
            m_lvl[c]  = 1'b0;
            m_tog[c]  = 1'b0;
            m_rise[c] = 1'b0;
            m_run[c]  = 0;
        end
    endtask

    task automatic step(input logic sx, input logic sy);
        logic sw[2];
        exp_t e;
        SW_X  = sx;
        SW_Y  = sy;
        sw[0] = sx;
        sw[1] = sy;
        for (int c = 0; c < 2; c++) begin
            m_rise[c] = 1'b0;
            if (m_s2[c] != m_lvl[c]) begin
                m_run[c]++;
                if (m_run[c] == D + 1) begin
                    m_lvl[c] = m_s2[c];
                    m_run[c] = 0;
                    if (m_lvl[c]) begin
                        m_rise[c] = 1'b1;
                        m_tog[c]  = ~m_tog[c];
                    end
                end
            end else begin
                m_run[c] = 0;
            end
            m_s2[c] = m_s1[c];
            m_s1[c] = sw[c];
        end
`ifdef TOGGLE_MODE_EN
        e.x = m_tog[0];
        e.y = m_tog[1];
`else
        e.x = m_lvl[0];
        e.y = m_lvl[1];
`endif
        e.xr = m_rise[0];
        e.yr = m_rise[1];
        sb_q.push_back(e);
        @(posedge CLK);
        #1;
        cyc++;
        e = sb_q.pop_front();
        check_bits($sformatf("cycle_%0d", cyc), {X, Y, X_RISE, Y_RISE}, {e.x, e.y, e.xr, e.yr});
        if (X_RISE) seg_xr++;
        if (Y_RISE) seg_yr++;
    endtask

    // Called #1 after an edge: outputs must clear before any further edge.
    task automatic do_reset(input string name);
        RST = 1'b1;
        #2;
        check_bits(name, {X, Y, X_RISE, Y_RISE}, 4'b0000);
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    initial begin
        int rise_edge;
        int n_rise;
        logic [2:0] tog_seq;

        RST  = 1'b1;
        SW_X = 1'b0;
        SW_Y = 1'b0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check_bits("reset_state", {X, Y, X_RISE, Y_RISE}, 4'b0000);
        RST = 1'b0;

        //                sx    sy    n   ex    ey    exr eyr name
        vecs.push_back('{1'b1, 1'b0, 20, 1'b1, 1'b0, 1, 0, "x_press"});
        vecs.push_back('{1'b0, 1'b0, 20, 1'b0, 1'b0, 0, 0, "x_release"});
        vecs.push_back('{1'b1, 1'b0, 3,  1'b0, 1'b0, 0, 0, "x_glitch3"});
        vecs.push_back('{1'b0, 1'b0, 10, 1'b0, 1'b0, 0, 0, "x_glitch3_after"});
        vecs.push_back('{1'b1, 1'b1, 20, 1'b1, 1'b1, 1, 1, "xy_press"});
        vecs.push_back('{1'b0, 1'b0, 20, 1'b0, 1'b0, 0, 0, "xy_release"});
        vecs.push_back('{1'b1, 1'b0, 4,  1'b0, 1'b0, 0, 0, "x_glitch4"});
        vecs.push_back('{1'b0, 1'b0, 10, 1'b0, 1'b0, 0, 0, "x_glitch4_after"});
        vecs.push_back('{1'b1, 1'b0, 5,  1'b0, 1'b0, 0, 0, "x_pulse5"});
        vecs.push_back('{1'b0, 1'b0, 15, 1'b0, 1'b0, 1, 0, "x_pulse5_after"});
        vecs.push_back('{1'b0, 1'b1, 1,  1'b0, 1'b0, 0, 0, "y_bounce_a"});
        vecs.push_back('{1'b0, 1'b0, 1,  1'b0, 1'b0, 0, 0, "y_bounce_b"});
        vecs.push_back('{1'b0, 1'b1, 2,  1'b0, 1'b0, 0, 0, "y_bounce_c"});
        vecs.push_back('{1'b0, 1'b0, 1,  1'b0, 1'b0, 0, 0, "y_bounce_d"});
        vecs.push_back('{1'b0, 1'b1, 15, 1'b0, 1'b1, 0, 1, "y_bounce_settle"});
        vecs.push_back('{1'b0, 1'b0, 15, 1'b0, 1'b0, 0, 0, "y_release"});

        for (int v = 0; v < vecs.size(); v++) begin
            seg_xr = 0;
            seg_yr = 0;
            repeat (vecs[v].n) step(vecs[v].sx, vecs[v].sy);
`ifndef TOGGLE_MODE_EN
            check_bits({vecs[v].name, "_level"}, {X, Y, 2'b00},
                       {vecs[v].ex, vecs[v].ey, 2'b00});
`endif
            check_int({vecs[v].name, "_xrise_count"}, seg_xr, vecs[v].exr);
            check_int({vecs[v].name, "_yrise_count"}, seg_yr, vecs[v].eyr);
        end

        // Reset mid-qualification: X settled high, Y part-way through its check window.
        repeat (20) step(1'b1, 1'b0);
        repeat (4) step(1'b1, 1'b1);
        do_reset("async_reset_mid_run");
        rise_edge = -1;
        n_rise    = 0;
        for (int i = 1; i <= 12; i++) begin
            step(1'b1, 1'b1);
            if (X_RISE) begin
                n_rise++;
                if (rise_edge < 0) rise_edge = i;
            end
        end
        check_int("post_reset_rise_edge", rise_edge, int'(D) + 3);
        check_int("post_reset_rise_count", n_rise, 1);
        check_bits("post_reset_level", {X, Y, 2'b00}, 4'b1100);
        repeat (15) step(1'b0, 1'b0);

`ifdef TOGGLE_MODE_EN
        @(posedge CLK);
        #1;
        do_reset("toggle_reset");
        seg_xr = 0;
        for (int p = 0; p < 3; p++) begin
            repeat (10) step(1'b1, 1'b0);
            tog_seq[p] = X;
            repeat (10) step(1'b0, 1'b0);
        end
        check_int("toggle_sequence", int'(tog_seq), 3'b101);
        check_int("toggle_rise_count", seg_xr, 3);
`else
        tog_seq = 3'b000;
`endif

        if (sb_q.size() != 0) check_int("scoreboard_drain", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Upstream conditioning stage for the two-input Moore/Mealy state machine lab block.
- Takes raw, bouncy, asynchronous switch levels SW_X/SW_Y and produces clean, synchronous, debounced levels X/Y that connect directly to the FSM's X/Y inputs.
- Also produces one-cycle rise pulses for each channel.
- Two identical, independent channels; one clock domain.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable synchronized cycles required to accept a new level. Legal range 1..2**CNT_W-1.
- CNT_W, 8, width of each per-channel stability counter.

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- RST  input  1  asynchronous, active-high reset.
- SW_X  input  1  raw switch level, channel X, asynchronous to CLK.
- SW_Y  input  1  raw switch level, channel Y, asynchronous to CLK.
- X  output  1  debounced level, channel X, registered.
- Y  output  1  debounced level, channel Y, registered.
- X_RISE  output  1  one-cycle pulse when X goes 0->1, registered.
- Y_RISE  output  1  one-cycle pulse when Y goes 0->1, registered.

Behaviour:
- Reset: RST=1 immediately forces the following, independent of CLK:
  - both sync flops of each channel to 0;
  - counters to 0;
  - channel FSMs to STABLE_LO;
  - X=Y=X_RISE=Y_RISE=0.
- Reset mid-operation: in-progress qualifications are discarded; no pulse is emitted on reset exit.
- Synchronizer: per channel, two-flop chain sw -> s1 -> s2. Only s2 is used downstream.
- Per-channel FSM, 4 states, evaluated on every rising edge:
  - STABLE_LO (out=0): if s2=1, go to CHK_HI with cnt<=0; else stay.
  - CHK_HI (out=0):
    - s2=0: return to STABLE_LO (glitch rejected, no output change);
    - s2=1 and cnt==DEBOUNCE_CYCLES-1: go to STABLE_HI, out<=1, rise<=1;
    - otherwise cnt<=cnt+1.
  - STABLE_HI (out=1): if s2=0, go to CHK_LO with cnt<=0; else stay.
  - CHK_LO (out=1):
    - s2=1: return to STABLE_HI;
    - s2=0 and cnt==DEBOUNCE_CYCLES-1: go to STABLE_LO, out<=0;
    - otherwise cnt<=cnt+1.
- Rise pulse:
  - High for exactly one cycle, on the same edge that out goes 0->1.
  - Deasserts on the next edge unconditionally.
  - No pulse on 1->0 transitions.
- Latency: raw input held stable from before edge e1 -> output changes at edge e(DEBOUNCE_CYCLES+3). With the default this is edge 7.
- Glitch rejection: any s2 excursion shorter than DEBOUNCE_CYCLES+1 cycles produces no output change.
- Counter: never exceeds DEBOUNCE_CYCLES-1, so no wrap-around.
- Channels are fully independent; simultaneous edges on SW_X and SW_Y qualify in parallel with identical latency.
- X/Y are glitch-free registered outputs and are safe to feed the FSM directly.

Optional Feature:
- Macro: TOGGLE_MODE_EN.
- Defined:
  - X and Y become latched toggles: each accepted 0->1 debounced transition inverts the corresponding output.
  - Accepted 1->0 transitions do not change X/Y.
  - X_RISE/Y_RISE still pulse on every accepted press.
  - Reset value of X/Y is 0.
- Undefined: X/Y follow the debounced level as described in Behaviour.
- The internal FSM and latency are identical in both builds.

Test Plan:
1. Assert RST=1 while SW_X=SW_Y=1 and the FSMs are mid-CHK_HI; release RST -> all outputs 0 immediately; X rises 7 edges after release; X_RISE high for exactly that one cycle.
2. SW_X 0->1, held 20 cycles, DEBOUNCE_CYCLES=4 -> X=1 at edge 7; X_RISE=1 only on edge 7; Y stays 0.
3. SW_X high-glitch lasting 3 cycles, then 0 -> X stays 0 throughout; X_RISE never asserts; FSM ends in STABLE_LO.
4. SW_X and SW_Y rise on the same cycle -> X and Y both go 1 on edge 7; X_RISE and Y_RISE pulse together; release both -> both return to 0 seven edges later with no pulses.
5. Bounce pattern 1,0,1,1,0,1,1,1,1,1,... on SW_Y -> Y rises only after 4+ consecutive stable s2 highs; exactly one Y_RISE pulse.
6. TOGGLE_MODE_EN defined: three clean presses (each held 10 cycles, released 10 cycles) on SW_X -> X sequence 1,0,1; three X_RISE pulses.
